// File: rtl/alu_cc_stage_if.sv
// Handshake and data bundle between an issuing datapath and the alu_cc_stage execute unit.
// The stage itself connects through the slave modport.
interface alu_cc_stage_if #(
  parameter int unsigned WIDTH = 64
) ();

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_fun;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             set_cc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] val_e;
  logic [2:0]       res_cc;
  logic [2:0]       cc;
  logic [2:0]       cond_fn;
  logic             cnd;

  modport master (
    output in_valid, alu_fun, op_a, op_b, set_cc, out_ready, cond_fn,
    input  in_ready, out_valid, val_e, res_cc, cc, cnd
  );

  modport slave (
    input  in_valid, alu_fun, op_a, op_b, set_cc, out_ready, cond_fn,
    output in_ready, out_valid, val_e, res_cc, cc, cnd
  );

endinterface

// File: rtl/alu_cc_stage.sv
// Registered ADD/SUB/AND/XOR execute stage with valid/ready handshakes, an architectural
// {OF,SF,ZF} condition-code register and Y86 branch/cmov condition evaluation.
module alu_cc_stage #(
  parameter int unsigned WIDTH    = 64,
  parameter logic [2:0]  CC_RESET = 3'b001
) (
  input logic          clk,
  input logic          reset,
  alu_cc_stage_if.slave bus
);

  typedef enum logic [1:0] {
    FunAdd = 2'd0,
    FunSub = 2'd1,
    FunAnd = 2'd2,
    FunXor = 2'd3
  } alu_fun_e;

  typedef enum logic [2:0] {
    CondAlways = 3'd0,
    CondLe     = 3'd1,
    CondL      = 3'd2,
    CondE      = 3'd3,
    CondNe     = 3'd4,
    CondGe     = 3'd5,
    CondG      = 3'd6,
    CondRsvd   = 3'd7
  } cond_fn_e;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [2:0]       res_cc_q, res_cc_d;
  logic [2:0]       cc_q, cc_d;

  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic             alu_of;
  logic [2:0]       alu_flags;
  logic             a_msb, b_msb, r_msb;

  // A full output register still accepts when the consumer drains it in the same cycle.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  assign a_msb = bus.op_a[WIDTH-1];
  assign b_msb = bus.op_b[WIDTH-1];
  assign r_msb = alu_res[WIDTH-1];

  always_comb begin
    alu_res = '0;
    unique case (alu_fun_e'(bus.alu_fun))
      FunAdd: alu_res = bus.op_b + bus.op_a;
      FunSub: alu_res = bus.op_b - bus.op_a;
      FunAnd: alu_res = bus.op_b & bus.op_a;
      FunXor: alu_res = bus.op_b ^ bus.op_a;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    alu_of = 1'b0;
    unique case (alu_fun_e'(bus.alu_fun))
      FunAdd: alu_of = (a_msb == b_msb) && (r_msb != a_msb);
      // SUB computes b - a, so overflow is judged against b's sign.
      FunSub: alu_of = (a_msb != b_msb) && (r_msb != b_msb);
      FunAnd: alu_of = 1'b0;
      FunXor: alu_of = 1'b0;
      default: alu_of = 1'b0;
    endcase
  end

  assign alu_flags = {alu_of, r_msb, (alu_res == '0)};

  always_comb begin
    out_valid_d = out_valid_q;
    val_d       = val_q;
    res_cc_d    = res_cc_q;
    cc_d        = cc_q;
    if (accept) begin
      out_valid_d = 1'b1;
      val_d       = alu_res;
      res_cc_d    = alu_flags;
      if (bus.set_cc) begin
        cc_d = alu_flags;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      val_q       <= '0;
      res_cc_q    <= 3'b000;
      cc_q        <= CC_RESET;
    end else begin
      out_valid_q <= out_valid_d;
      val_q       <= val_d;
      res_cc_q    <= res_cc_d;
      cc_q        <= cc_d;
    end
  end

  logic cc_of, cc_sf, cc_zf, sf_ne_of;
  logic cnd;

  assign cc_of    = cc_q[2];
  assign cc_sf    = cc_q[1];
  assign cc_zf    = cc_q[0];
  assign sf_ne_of = cc_sf ^ cc_of;

  always_comb begin
    cnd = 1'b0;
    unique case (cond_fn_e'(bus.cond_fn))
      CondAlways: cnd = 1'b1;
      CondLe:     cnd = sf_ne_of | cc_zf;
      CondL:      cnd = sf_ne_of;
      CondE:      cnd = cc_zf;
      CondNe:     cnd = !cc_zf;
      CondGe:     cnd = !sf_ne_of;
      CondG:      cnd = !sf_ne_of && !cc_zf;
      CondRsvd:   cnd = 1'b0;
      default:    cnd = 1'b0;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.val_e     = val_q;
  assign bus.res_cc    = res_cc_q;
  assign bus.cc        = cc_q;
  assign bus.cnd       = cnd;

endmodule

// File: tb/tb_alu_cc_stage.sv
// Directed and randomized checks of alu_cc_stage at WIDTH=64 and WIDTH=8 against a
// signed-arithmetic reference model and an in-order result scoreboard.
module tb_alu_cc_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_cc_stage_if #(.WIDTH(64)) b64 ();
  alu_cc_stage_if #(.WIDTH(8))  b8 ();

  alu_cc_stage #(.WIDTH(64), .CC_RESET(3'b001)) u_dut64 (
    .clk   (clk),
    .reset (reset),
    .bus   (b64.slave)
  );

  alu_cc_stage #(.WIDTH(8), .CC_RESET(3'b001)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (b8.slave)
  );

  typedef struct {
    logic [63:0] val;
    logic [2:0]  f;
  } exp_t;

  exp_t       q[$];
  logic [2:0] mcc;
  logic [2:0] mcc8;
  int         n_asserts = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact signed arithmetic in 65 bits, overflow = result outside 64-bit range.
  function automatic void model64(input logic [1:0] fun, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] r,
                                  output logic [2:0] f);
    logic signed [64:0] ea, eb, full;
    logic of;
    ea = $signed({a[63], a});
    eb = $signed({b[63], b});
    case (fun)
      2'd0: full = eb + ea;
      2'd1: full = eb - ea;
      2'd2: full = $signed({1'b0, a & b});
      default: full = $signed({1'b0, a ^ b});
    endcase
    r  = full[63:0];
    of = (fun <= 2'd1) && ((full > $signed({2'b00, {63{1'b1}}})) ||
                           (full < $signed({2'b11, 63'd0})));
    f  = {of, r[63], (r == 64'd0)};
  endfunction

  function automatic void model8(input logic [1:0] fun, input logic [7:0] a,
                                 input logic [7:0] b, output logic [7:0] r,
                                 output logic [2:0] f);
    int sa, sb, full;
    logic of;
    sa = int'($signed(a));
    sb = int'($signed(b));
    of = 1'b0;
    case (fun)
      2'd0: begin full = sb + sa; of = (full > 127) || (full < -128); r = full[7:0]; end
      2'd1: begin full = sb - sa; of = (full > 127) || (full < -128); r = full[7:0]; end
      2'd2: r = a & b;
      default: r = a ^ b;
    endcase
    f = {of, r[7], (r == 8'd0)};
  endfunction

  function automatic logic model_cnd(input logic [2:0] c, input logic [2:0] fn);
    logic lt;
    lt = (c[1] != c[2]);
    case (fn)
      3'd0: return 1'b1;
      3'd1: return lt || c[0];
      3'd2: return lt;
      3'd3: return c[0];
      3'd4: return !c[0];
      3'd5: return !lt;
      3'd6: return !lt && !c[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return {64{1'b1}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Check the 64-bit stage against the scoreboard, then advance one clock.
  task automatic tick(output bit acc);
    exp_t        e;
    logic [63:0] r;
    logic [2:0]  f;
    bit          drain;
    #1;
    chk("in_ready", 64'(b64.in_ready), 64'((q.size() == 0) || b64.out_ready));
    chk("out_valid", 64'(b64.out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("val_e", b64.val_e, q[0].val);
      chk("res_cc", 64'(b64.res_cc), 64'(q[0].f));
    end
    chk("cc", 64'(b64.cc), 64'(mcc));
    chk("cnd", 64'(b64.cnd), 64'(model_cnd(mcc, b64.cond_fn)));
    drain = (q.size() != 0) && b64.out_ready;
    acc   = b64.in_valid && ((q.size() == 0) || b64.out_ready);
    if (drain) void'(q.pop_front());
    if (acc) begin
      model64(b64.alu_fun, b64.op_a, b64.op_b, r, f);
      e.val = r;
      e.f   = f;
      q.push_back(e);
      if (b64.set_cc) mcc = f;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive64(input logic v, input logic [1:0] fun, input logic [63:0] a,
                         input logic [63:0] b, input logic sc);
    b64.in_valid = v;
    b64.alu_fun  = fun;
    b64.op_a     = a;
    b64.op_b     = b;
    b64.set_cc   = sc;
  endtask

  initial begin
    bit          acc;
    int          sent;
    logic [63:0] bp_a[3];
    logic [7:0]  r8;
    logic [2:0]  f8;
    logic [1:0]  fun8;
    logic [7:0]  a8, b8v;

    drive64(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
    b64.out_ready = 1'b0;
    b64.cond_fn   = 3'd3;
    b8.in_valid   = 1'b0;
    b8.alu_fun    = 2'd0;
    b8.op_a       = 8'd0;
    b8.op_b       = 8'd0;
    b8.set_cc     = 1'b0;
    b8.out_ready  = 1'b1;
    b8.cond_fn    = 3'd0;
    mcc  = 3'b001;
    mcc8 = 3'b001;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(b64.out_valid), 64'd0);
    chk("rst_val_e", b64.val_e, 64'd0);
    chk("rst_res_cc", 64'(b64.res_cc), 64'd0);
    chk("rst_cc", 64'(b64.cc), 64'd1);
    chk("rst_cnd_e", 64'(b64.cnd), 64'd1);
    chk("rst_cc8", 64'(b8.cc), 64'd1);
    reset = 1'b0;

    // ADD overflow, held with out_ready low so the later reset hits a pending result.
    drive64(1'b1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    tick(acc);
    drive64(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
    chk("add_ovf_val", b64.val_e, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("add_ovf_res_cc", 64'(b64.res_cc), 64'b110);
    chk("add_ovf_cc", 64'(b64.cc), 64'b110);
    b64.cond_fn = 3'd2;
    #1;
    chk("add_ovf_cnd_l", 64'(b64.cnd), 64'd0);

    // Asynchronous reset between edges.
    reset = 1'b1;
    b64.cond_fn = 3'd3;
    #1;
    chk("async_rst_out_valid", 64'(b64.out_valid), 64'd0);
    chk("async_rst_val_e", b64.val_e, 64'd0);
    chk("async_rst_cc", 64'(b64.cc), 64'b001);
    chk("async_rst_cnd_e", 64'(b64.cnd), 64'd1);
    q.delete();
    mcc = 3'b001;
    reset = 1'b0;

    // SUB equality, then XOR with set_cc=0 issued while draining.
    b64.out_ready = 1'b1;
    drive64(1'b1, 2'd1, 64'd5, 64'd5, 1'b1);
    tick(acc);
    chk("sub_eq_val", b64.val_e, 64'd0);
    chk("sub_eq_cc", 64'(b64.cc), 64'b001);
    chk("sub_eq_cnd_e", 64'(b64.cnd), 64'd1);
    drive64(1'b1, 2'd3, 64'd1, 64'd2, 1'b0);
    tick(acc);
    chk("xor_val", b64.val_e, 64'd3);
    chk("xor_res_cc", 64'(b64.res_cc), 64'b000);
    chk("xor_cc_kept", 64'(b64.cc), 64'b001);
    drive64(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
    tick(acc);

    // Backpressure: three ADDs (b=100), out_ready low for the first three cycles.
    bp_a[0] = 64'd1;
    bp_a[1] = 64'd2;
    bp_a[2] = 64'd3;
    sent = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      b64.out_ready = (cyc >= 3);
      if (sent < 3) drive64(1'b1, 2'd0, bp_a[sent], 64'd100, 1'b0);
      else drive64(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
      tick(acc);
      if (acc) sent++;
      if (cyc >= 0 && cyc < 2) begin
        chk("bp_hold_val", b64.val_e, 64'd101);
        chk("bp_in_ready_low", 64'(b64.in_ready), 64'd0);
      end
    end
    chk("bp_all_sent", 64'(sent), 64'd3);
    chk("bp_drained", 64'(q.size()), 64'd0);

    // Throughput: 8 back-to-back ANDs.
    b64.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive64(1'b1, 2'd2, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
      tick(acc);
      chk("thru_accept", 64'(acc), 64'd1);
      chk("thru_out_valid", 64'(b64.out_valid), 64'd1);
    end
    drive64(1'b1, 2'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1);
    tick(acc);
    chk("sub_of_val", b64.val_e, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("sub_of_res_cc", 64'(b64.res_cc), 64'b100);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 300; i++) begin
      drive64(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), rand_op(), rand_op(),
              1'($urandom_range(0, 1)));
      b64.out_ready = ($urandom_range(0, 3) != 0);
      b64.cond_fn   = 3'($urandom_range(0, 7));
      tick(acc);
    end
    drive64(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
    b64.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick(acc);
    chk("final_drained", 64'(q.size()), 64'd0);

    // WIDTH=8 instance.
    b8.in_valid = 1'b1;
    b8.alu_fun  = 2'd0;
    b8.op_a     = 8'h80;
    b8.op_b     = 8'h80;
    b8.set_cc   = 1'b1;
    @(posedge clk);
    #1;
    b8.in_valid = 1'b0;
    b8.cond_fn  = 3'd1;
    #1;
    chk("w8_add_val", 64'(b8.val_e), 64'h00);
    chk("w8_add_cc", 64'(b8.cc), 64'b101);
    chk("w8_cnd_le", 64'(b8.cnd), 64'd1);
    mcc8 = 3'b101;
    for (int i = 0; i < 24; i++) begin
      fun8 = 2'($urandom_range(0, 3));
      a8   = 8'($urandom);
      b8v  = 8'($urandom);
      b8.in_valid = 1'b1;
      b8.alu_fun  = fun8;
      b8.op_a     = a8;
      b8.op_b     = b8v;
      b8.set_cc   = 1'($urandom_range(0, 1));
      b8.cond_fn  = 3'($urandom_range(0, 7));
      model8(fun8, a8, b8v, r8, f8);
      if (b8.set_cc) mcc8 = f8;
      @(posedge clk);
      #1;
      chk("w8_val", 64'(b8.val_e), 64'(r8));
      chk("w8_res_cc", 64'(b8.res_cc), 64'(f8));
      chk("w8_cc", 64'(b8.cc), 64'(mcc8));
      chk("w8_cnd", 64'(b8.cnd), 64'(model_cnd(mcc8, b8.cond_fn)));
    end
    b8.in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
